// File: rtl/prt_phy_rcfg_rsp.sv
// -----------------------------------------------------------------------------
// prt_phy_rcfg_rsp
//
// Target end of the PHY reconfig bus. It models one transceiver reconfig
// slave as a bank of P_WORDS registers. Accesses take a programmable number
// of extra wait cycles, and STALL_IN can lengthen them further. Each access
// completes with a single cycle of RCFG_WAIT_OUT low. For reads,
// RCFG_DAT_OUT is valid in that same cycle.
//
// Ports
//   RST_IN         asynchronous active-high reset
//   CLK_IN         clock
//   RCFG_ADR_IN    access address, captured in IDLE
//   RCFG_WR_IN     write request, held by the master until acknowledged
//   RCFG_RD_IN     read request, held by the master until acknowledged
//   RCFG_DAT_IN    write data, captured in IDLE
//   RCFG_DAT_OUT   read data; updated only on a read acknowledge
//   RCFG_WAIT_OUT  wait request; high except in the single acknowledge cycle
//   STALL_IN       freezes an access in BUSY while high
//   ERR_CLR_IN     clears ERR_OUT (a simultaneous new error wins)
//   ERR_OUT        sticky protocol error (WR+RD together, or request dropped)
//   WR_CNT_OUT     completed writes, wrapping
//   RD_CNT_OUT     completed reads, wrapping
// -----------------------------------------------------------------------------
module prt_phy_rcfg_rsp #(
  parameter int                    P_RCFG_ADR = 10,
  parameter int                    P_RCFG_DAT = 32,
  parameter int                    P_WORDS    = 16,
  parameter int                    P_LAT      = 2,
  parameter logic [P_RCFG_DAT-1:0] P_OOR_DAT  = P_RCFG_DAT'(32'hDEADBEEF),
  parameter int                    P_CNT      = 16
) (
  input  logic                  RST_IN,
  input  logic                  CLK_IN,
  input  logic [P_RCFG_ADR-1:0] RCFG_ADR_IN,
  input  logic                  RCFG_WR_IN,
  input  logic                  RCFG_RD_IN,
  input  logic [P_RCFG_DAT-1:0] RCFG_DAT_IN,
  output logic [P_RCFG_DAT-1:0] RCFG_DAT_OUT,
  output logic                  RCFG_WAIT_OUT,
  input  logic                  STALL_IN,
  input  logic                  ERR_CLR_IN,
  output logic                  ERR_OUT,
  output logic [P_CNT-1:0]      WR_CNT_OUT,
  output logic [P_CNT-1:0]      RD_CNT_OUT
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  localparam int LAT_W = (P_LAT > 0) ? $clog2(P_LAT + 1) : 1;
  localparam int IDX_W = (P_WORDS > 1) ? $clog2(P_WORDS) : 1;

  logic [1:0]            state;
  logic [LAT_W-1:0]      lat_cnt;
  logic [P_RCFG_ADR-1:0] cap_adr;
  logic [P_RCFG_DAT-1:0] cap_dat;
  logic                  cap_wr;
  logic [P_RCFG_DAT-1:0] regs [P_WORDS];

  logic             req_one;
  logic             req_both;
  logic             req_held;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             busy_abort;
  logic             busy_done;
  logic             err_set;

  assign req_one  = RCFG_WR_IN ^ RCFG_RD_IN;
  assign req_both = RCFG_WR_IN & RCFG_RD_IN;
  // In BUSY only the request line of the captured operation is watched.
  assign req_held = cap_wr ? RCFG_WR_IN : RCFG_RD_IN;
  // One extra bit so that P_WORDS == 2**P_RCFG_ADR does not truncate to zero.
  assign in_range = {1'b0, cap_adr} < (P_RCFG_ADR + 1)'(P_WORDS);
  assign idx      = cap_adr[IDX_W-1:0];

  assign busy_abort = (state == S_BUSY) && !req_held;
  assign busy_done  = (state == S_BUSY) && req_held && !STALL_IN && (lat_cnt == '0);
  assign err_set    = ((state == S_IDLE) && req_both) || busy_abort;

  // Control path, captured request and all registered outputs.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state         <= S_IDLE;
      lat_cnt       <= '0;
      cap_adr       <= '0;
      cap_dat       <= '0;
      cap_wr        <= 1'b0;
      RCFG_WAIT_OUT <= 1'b1;
      RCFG_DAT_OUT  <= '0;
      ERR_OUT       <= 1'b0;
      WR_CNT_OUT    <= '0;
      RD_CNT_OUT    <= '0;
    end else begin
      // Set has priority over clear so that no error is lost.
      ERR_OUT <= err_set | (ERR_OUT & ~ERR_CLR_IN);
      case (state)
        S_IDLE: begin
          if (req_both) begin
            // Null access: acknowledge so the master is not left hanging.
            state         <= S_ACK;
            RCFG_WAIT_OUT <= 1'b0;
          end else if (req_one) begin
            state   <= S_BUSY;
            cap_adr <= RCFG_ADR_IN;
            cap_dat <= RCFG_DAT_IN;
            cap_wr  <= RCFG_WR_IN;
            lat_cnt <= LAT_W'(P_LAT);
          end
        end
        S_BUSY: begin
          if (busy_abort) begin
            state <= S_IDLE;
          end else if (!STALL_IN) begin
            if (lat_cnt == '0) begin
              state         <= S_ACK;
              RCFG_WAIT_OUT <= 1'b0;
              if (cap_wr) begin
                WR_CNT_OUT <= WR_CNT_OUT + 1'b1;
              end else begin
                RD_CNT_OUT   <= RD_CNT_OUT + 1'b1;
                RCFG_DAT_OUT <= in_range ? regs[idx] : P_OOR_DAT;
              end
            end else begin
              lat_cnt <= lat_cnt - 1'b1;
            end
          end
        end
        S_ACK: begin
          state         <= S_IDLE;
          RCFG_WAIT_OUT <= 1'b1;
        end
        default: begin
          state         <= S_IDLE;
          RCFG_WAIT_OUT <= 1'b1;
        end
      endcase
    end
  end

  // NOTE: the register bank gets an explicit reset loop, unlike a typical
  // memory. A reset in the middle of an access has to leave every register
  // at zero, so this bank must be built from flops and cannot be a RAM macro.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      for (int i = 0; i < P_WORDS; i++) begin
        regs[i] <= '0;
      end
    end else if (busy_done && cap_wr && in_range) begin
      regs[idx] <= cap_dat;
    end
  end

endmodule

// File: tb/tb_prt_phy_rcfg_rsp.sv
module tb_prt_phy_rcfg_rsp;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Instance a: default parameters (P_LAT=2, P_CNT=16)
  logic [9:0]  adr;
  logic        wr, rd, stall, err_clr;
  logic [31:0] wdat, rdat;
  logic        waitreq, err;
  logic [15:0] wr_cnt, rd_cnt;

  // Instance b: P_LAT=0, P_CNT=4
  logic [9:0]  b_adr;
  logic        b_wr, b_rd, b_stall, b_err_clr;
  logic [31:0] b_wdat, b_rdat;
  logic        b_waitreq, b_err;
  logic [3:0]  b_wr_cnt, b_rd_cnt;

  prt_phy_rcfg_rsp dut (
    .RST_IN(rst), .CLK_IN(clk), .RCFG_ADR_IN(adr), .RCFG_WR_IN(wr), .RCFG_RD_IN(rd),
    .RCFG_DAT_IN(wdat), .RCFG_DAT_OUT(rdat), .RCFG_WAIT_OUT(waitreq), .STALL_IN(stall),
    .ERR_CLR_IN(err_clr), .ERR_OUT(err), .WR_CNT_OUT(wr_cnt), .RD_CNT_OUT(rd_cnt)
  );

  prt_phy_rcfg_rsp #(.P_LAT(0), .P_CNT(4)) dut_b (
    .RST_IN(rst), .CLK_IN(clk), .RCFG_ADR_IN(b_adr), .RCFG_WR_IN(b_wr), .RCFG_RD_IN(b_rd),
    .RCFG_DAT_IN(b_wdat), .RCFG_DAT_OUT(b_rdat), .RCFG_WAIT_OUT(b_waitreq), .STALL_IN(b_stall),
    .ERR_CLR_IN(b_err_clr), .ERR_OUT(b_err), .WR_CNT_OUT(b_wr_cnt), .RD_CNT_OUT(b_rd_cnt)
  );

  localparam int LAT = 2;

  int tests = 0;
  int fails = 0;

  // Behavioural model of instance a: register contents, counters, last read data.
  logic [31:0] m_regs [16];
  int          m_wr, m_rd;
  logic [31:0] m_rdat;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_wr = 0; m_rd = 0; m_rdat = '0;
  endtask

  task automatic model_access(input bit is_wr, input logic [9:0] a, input logic [31:0] d,
                              output logic [31:0] exp_rdat);
    if (is_wr) begin
      if (a < 16) m_regs[a[3:0]] = d;
      m_wr = (m_wr + 1) % 65536;
    end else begin
      m_rdat = (a < 16) ? m_regs[a[3:0]] : 32'hDEADBEEF;
      m_rd = (m_rd + 1) % 65536;
    end
    exp_rdat = m_rdat;
  endtask

  // Master driver for instance a. Called at a negedge. Cycle t is the cycle in
  // which the DUT (in IDLE) samples the request; b2b means the call is made
  // during the previous ACK cycle, so cycle t is the next one. lat is the
  // number of cycles from t to the WAIT-low cycle (-1 on timeout).
  task automatic access(input bit is_wr, input logic [9:0] a, input logic [31:0] d,
                        input int st_start, input int st_len, input bit b2b,
                        output int lat, output logic [31:0] rd_val);
    int n;
    n = b2b ? -1 : 0;
    lat = -1;
    rd_val = 'x;
    adr = a; wdat = d; wr = is_wr; rd = !is_wr;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      n++;
      if (!waitreq) begin
        lat = n;
        rd_val = rdat;
        break;
      end
      if (n == 1) begin
        adr = 10'($urandom);
        wdat = $urandom;
      end
      stall = (n >= st_start) && (n < st_start + st_len);
    end
    wr = 1'b0; rd = 1'b0; stall = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (waitreq !== 1'b1 || rdat !== 32'h0 || err !== 1'b0 || wr_cnt !== 16'h0 || rd_cnt !== 16'h0) begin
      fails++;
      $display("FAIL reset_a: wait=%b dat=%h err=%b wr=%0d rd=%0d, want 1 0 0 0 0", waitreq, rdat, err, wr_cnt, rd_cnt);
    end
    tests++;
    if (b_waitreq !== 1'b1 || b_rdat !== 32'h0 || b_err !== 1'b0 || b_wr_cnt !== 4'h0 || b_rd_cnt !== 4'h0) begin
      fails++;
      $display("FAIL reset_b: wait=%b dat=%h err=%b wr=%0d rd=%0d, want 1 0 0 0 0", b_waitreq, b_rdat, b_err, b_wr_cnt, b_rd_cnt);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    int lat; logic [31:0] got, exp;
    access(1'b1, 10'd3, 32'h12345678, 0, 0, 1'b0, lat, got);
    model_access(1'b1, 10'd3, 32'h12345678, exp);
    tests++;
    if (lat !== 2 + LAT) begin fails++; $display("FAIL basic_wr_lat: got %0d want %0d", lat, 2 + LAT); end
    @(negedge clk);
    tests++;
    if (waitreq !== 1'b1) begin fails++; $display("FAIL basic_ack_width: wait=%b want 1", waitreq); end
    access(1'b0, 10'd3, 32'h0, 0, 0, 1'b0, lat, got);
    model_access(1'b0, 10'd3, 32'h0, exp);
    tests++;
    if (lat !== 2 + LAT) begin fails++; $display("FAIL basic_rd_lat: got %0d want %0d", lat, 2 + LAT); end
    tests++;
    if (got !== exp) begin fails++; $display("FAIL basic_rd_dat: got %h want %h", got, exp); end
    tests++;
    if (wr_cnt !== 16'(m_wr) || rd_cnt !== 16'(m_rd)) begin
      fails++; $display("FAIL basic_cnt: wr=%0d rd=%0d want %0d %0d", wr_cnt, rd_cnt, m_wr, m_rd);
    end
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] got, exp;
    access(1'b0, 10'd20, 32'h0, 0, 0, 1'b0, lat, got);
    model_access(1'b0, 10'd20, 32'h0, exp);
    tests++;
    if (got !== 32'hDEADBEEF || lat !== 2 + LAT) begin fails++; $display("FAIL oor_rd1: dat=%h lat=%0d want deadbeef %0d", got, lat, 2 + LAT); end
    access(1'b1, 10'd20, 32'h1, 0, 0, 1'b1, lat, got);
    model_access(1'b1, 10'd20, 32'h1, exp);
    tests++;
    if (lat !== 2 + LAT || wr_cnt !== 16'(m_wr)) begin fails++; $display("FAIL oor_wr: lat=%0d wr_cnt=%0d want %0d %0d", lat, wr_cnt, 2 + LAT, m_wr); end
    access(1'b0, 10'd20, 32'h0, 0, 0, 1'b1, lat, got);
    model_access(1'b0, 10'd20, 32'h0, exp);
    tests++;
    if (got !== 32'hDEADBEEF) begin fails++; $display("FAIL oor_rd2: got %h want deadbeef", got); end
    for (int i = 0; i < 16; i++) begin
      access(1'b0, 10'(i), 32'h0, 0, 0, 1'b1, lat, got);
      model_access(1'b0, 10'(i), 32'h0, exp);
      tests++;
      if (got !== exp) begin fails++; $display("FAIL oor_regs[%0d]: got %h want %h", i, got, exp); end
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    int lat; logic [31:0] got, exp;
    access(1'b1, 10'd11, 32'hA5A5_0F0F, 0, 0, 1'b0, lat, got);
    model_access(1'b1, 10'd11, 32'hA5A5_0F0F, exp);
    access(1'b0, 10'd11, 32'h0, 2, 5, 1'b1, lat, got);
    model_access(1'b0, 10'd11, 32'h0, exp);
    tests++;
    if (lat !== 2 + LAT + 5) begin fails++; $display("FAIL stall_lat: got %0d want %0d", lat, 2 + LAT + 5); end
    tests++;
    if (got !== exp) begin fails++; $display("FAIL stall_dat: got %h want %h", got, exp); end
    @(negedge clk);
  endtask

  task automatic test_null_err();
    int lat; logic [31:0] got, exp;
    adr = 10'd3; wdat = 32'hFFFF_FFFF; wr = 1'b1; rd = 1'b1;
    @(negedge clk);
    tests++;
    if (waitreq !== 1'b0 || err !== 1'b1) begin fails++; $display("FAIL null_ack: wait=%b err=%b want 0 1", waitreq, err); end
    tests++;
    if (rdat !== m_rdat || wr_cnt !== 16'(m_wr) || rd_cnt !== 16'(m_rd)) begin
      fails++; $display("FAIL null_side: dat=%h wr=%0d rd=%0d want %h %0d %0d", rdat, wr_cnt, rd_cnt, m_rdat, m_wr, m_rd);
    end
    wr = 1'b0; rd = 1'b0;
    @(negedge clk);
    tests++;
    if (waitreq !== 1'b1 || err !== 1'b1) begin fails++; $display("FAIL null_after: wait=%b err=%b want 1 1", waitreq, err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL err_clear: err=%b want 0", err); end
    wr = 1'b1; rd = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; err_clr = 1'b0;
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL err_set_wins: err=%b want 1", err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    access(1'b0, 10'd3, 32'h0, 0, 0, 1'b0, lat, got);
    model_access(1'b0, 10'd3, 32'h0, exp);
    tests++;
    if (got !== exp) begin fails++; $display("FAIL null_reg: got %h want %h", got, exp); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int lat; int low_seen; logic [31:0] got, exp;
    adr = 10'd7; wdat = 32'hCAFE_F00D; wr = 1'b1; rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wr = 1'b0;
    low_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (waitreq !== 1'b1) low_seen++;
    end
    tests++;
    if (low_seen != 0) begin fails++; $display("FAIL abort_wait: %0d cycles low want 0", low_seen); end
    tests++;
    if (err !== 1'b1 || wr_cnt !== 16'(m_wr)) begin fails++; $display("FAIL abort_err: err=%b wr_cnt=%0d want 1 %0d", err, wr_cnt, m_wr); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    access(1'b0, 10'd7, 32'h0, 0, 0, 1'b0, lat, got);
    model_access(1'b0, 10'd7, 32'h0, exp);
    tests++;
    if (got !== exp) begin fails++; $display("FAIL abort_reg: got %h want %h", got, exp); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] got, exp;
    adr = 10'd9; wdat = 32'h0BAD_1DEA; wr = 1'b1; rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wr = 1'b0;
    #1;
    tests++;
    if (waitreq !== 1'b1 || rdat !== 32'h0 || err !== 1'b0 || wr_cnt !== 16'h0 || rd_cnt !== 16'h0) begin
      fails++; $display("FAIL reset_mid: wait=%b dat=%h err=%b wr=%0d rd=%0d want 1 0 0 0 0", waitreq, rdat, err, wr_cnt, rd_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    access(1'b0, 10'd9, 32'h0, 0, 0, 1'b0, lat, got);
    model_access(1'b0, 10'd9, 32'h0, exp);
    tests++;
    if (got !== exp) begin fails++; $display("FAIL reset_mid_reg9: got %h want %h", got, exp); end
    access(1'b0, 10'd3, 32'h0, 0, 0, 1'b1, lat, got);
    model_access(1'b0, 10'd3, 32'h0, exp);
    tests++;
    if (got !== exp) begin fails++; $display("FAIL reset_mid_reg3: got %h want %h", got, exp); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, st_start, st_len; bit is_wr, b2b; logic [9:0] a; logic [31:0] d, got, exp;
    b2b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      is_wr = 1'($urandom);
      a = 10'($urandom_range(0, 23));
      d = $urandom;
      st_start = $urandom_range(1, 1 + LAT);
      st_len = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
      access(is_wr, a, d, st_start, st_len, b2b, lat, got);
      model_access(is_wr, a, d, exp);
      tests++;
      if (lat !== 2 + LAT + st_len) begin fails++; $display("FAIL rand_lat[%0d]: got %0d want %0d", i, lat, 2 + LAT + st_len); end
      if (!is_wr) begin
        tests++;
        if (got !== exp) begin fails++; $display("FAIL rand_dat[%0d] adr %0d: got %h want %h", i, a, got, exp); end
      end
      b2b = 1'($urandom);
      if (!b2b) @(negedge clk);
    end
    if (b2b) @(negedge clk);
    tests++;
    if (wr_cnt !== 16'(m_wr) || rd_cnt !== 16'(m_rd)) begin
      fails++; $display("FAIL rand_cnt: wr=%0d rd=%0d want %0d %0d", wr_cnt, rd_cnt, m_wr, m_rd);
    end
  endtask

  task automatic test_back_to_back_wrap();
    int n, lat, bad;
    bad = 0;
    for (int i = 0; i < 17; i++) begin
      n = (i == 0) ? 0 : -1;
      lat = -1;
      b_adr = 10'(i % 16); b_wdat = $urandom; b_wr = 1'b1; b_rd = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        n++;
        if (!b_waitreq) begin lat = n; break; end
      end
      b_wr = 1'b0;
      if (lat != 2) begin
        bad++;
        $display("FAIL b2b_lat[%0d]: got %0d want 2", i, lat);
      end
    end
    tests++;
    if (bad != 0) fails++;
    @(negedge clk);
    tests++;
    if (b_waitreq !== 1'b1 || b_wr_cnt !== 4'd1 || b_rd_cnt !== 4'd0) begin
      fails++; $display("FAIL b2b_wrap: wait=%b wr_cnt=%0d rd_cnt=%0d want 1 1 0", b_waitreq, b_wr_cnt, b_rd_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    adr = '0; wr = 1'b0; rd = 1'b0; wdat = '0; stall = 1'b0; err_clr = 1'b0;
    b_adr = '0; b_wr = 1'b0; b_rd = 1'b0; b_wdat = '0; b_stall = 1'b0; b_err_clr = 1'b0;
    test_reset();
    test_basic();
    test_out_of_range();
    test_stall();
    test_null_err();
    test_abort();
    test_reset_mid();
    test_random();
    test_back_to_back_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
